fetch_queue_ctrl: RTL and testbench

Sequences instruction fetch on memory read port 0 and buffers the fetched instructions for decode. Each fetch is one aligned 64-bit read carrying two 32-bit instructions, which are written into a circular instruction queue. Decode drains the queue one instruction per cycle with a valid/ready handshake. A redirect from branch resolution flushes the queue, kills any read in flight and restarts fetch at the new PC.

---
 rtl/ppc_pkg.sv | 19 +
 rtl/fetch_queue_ctrl_if.sv | 56 +++++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_queue_ctrl.sv | 144 ++++++++++++++
 tb/tb_fetch_queue_ctrl.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/ppc_pkg.sv
// Shared fetch-side types and constants for the PPC front end.
// Big-endian bit numbering: bit 0 is the most significant bit.
package ppc_pkg;

    typedef logic [0:63] addr_t;
    typedef logic [0:31] inst_t;
    typedef logic [0:63] dword_t;

    localparam int unsigned INST_BYTES  = 4;
    localparam int unsigned DWORD_BYTES = 8;

    // Start of the doubleword that follows the one holding pc.
    function automatic addr_t next_dword(addr_t pc);
        addr_t base;
        base = pc & ~addr_t'(DWORD_BYTES - 1);
        return base + addr_t'(DWORD_BYTES);
    endfunction

endpackage

// File: rtl/fetch_queue_ctrl_if.sv
// Fetch control, memory read port 0 and decode handshake bundle.
// FETCH_QUEUE_PERF_EN adds the performance counter outputs.
interface fetch_queue_ctrl_if #(
    parameter int DEPTH = 16
) ();
    import ppc_pkg::*;

    localparam int CW = $clog2(DEPTH);

    logic          fetch_stall;
    logic          redirect_valid;
    addr_t         redirect_pc;
    logic          mem_rd_en;
    logic [0:60]   mem_rd_addr;
    dword_t        mem_rd_data;
    logic          inst_valid;
    logic          inst_ready;
    inst_t         inst;
    addr_t         inst_pc;
    logic [0:CW]   count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [0:31]   perf_stall_cycles;
    logic [0:31]   perf_redirects;

    modport master (
        output fetch_stall, redirect_valid, redirect_pc,
        output mem_rd_data, inst_ready,
        input  mem_rd_en, mem_rd_addr, inst_valid,
        input  inst, inst_pc, count,
        input  perf_stall_cycles, perf_redirects
    );

    modport slave (
        input  fetch_stall, redirect_valid, redirect_pc,
        input  mem_rd_data, inst_ready,
        output mem_rd_en, mem_rd_addr, inst_valid,
        output inst, inst_pc, count,
        output perf_stall_cycles, perf_redirects
    );
`else
    modport master (
        output fetch_stall, redirect_valid, redirect_pc,
        output mem_rd_data, inst_ready,
        input  mem_rd_en, mem_rd_addr, inst_valid,
        input  inst, inst_pc, count
    );

    modport slave (
        input  fetch_stall, redirect_valid, redirect_pc,
        input  mem_rd_data, inst_ready,
        output mem_rd_en, mem_rd_addr, inst_valid,
        output inst, inst_pc, count
    );
`endif

endinterface

// File: rtl/fetch_fifo.sv
// Circular instruction buffer: up to two pushes and one pop per cycle.
module fetch_fifo
    import ppc_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush_i,
    input  logic [1:0]        push_n_i,
    input  inst_t             push_w0_i,
    input  inst_t             push_w1_i,
    input  logic              pop_i,
    output inst_t             head_o,
    output logic [0:$clog2(DEPTH)] count_o
);

    localparam int CW = $clog2(DEPTH);

    typedef logic [CW-1:0] ptr_t;
    typedef logic [0:CW]   cnt_t;

    inst_t mem_q [DEPTH];
    ptr_t  wr_q, wr_d, rd_q, rd_d, wr_nx;
    cnt_t  count_q, count_d;

    assign wr_nx = wr_q + ptr_t'(1);

    always_comb begin
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        if (flush_i) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else begin
            wr_d    = wr_q + ptr_t'(push_n_i);
            rd_d    = rd_q + ptr_t'(pop_i);
            count_d = count_q + cnt_t'(push_n_i) - cnt_t'(pop_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset; count gates every read of it.
    always_ff @(posedge clk) begin
        if (!flush_i) begin
            if (push_n_i != 2'd0)
                mem_q[wr_q] <= push_w0_i;
            if (push_n_i == 2'd2)
                mem_q[wr_nx] <= push_w1_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// Instruction fetch sequencer feeding a circular queue toward decode.
// FETCH_QUEUE_PERF_EN adds saturating stall and redirect counters.
module fetch_queue_ctrl
    import ppc_pkg::*;
#(
    parameter int    DEPTH    = 16,
    parameter addr_t RESET_PC = 64'h0
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_queue_ctrl_if.slave  bus
);

    localparam int CW = $clog2(DEPTH);
    localparam int NW = CW + 3;

    typedef logic [NW-1:0] need_t;

    addr_t         fetch_pc_q, fetch_pc_d;
    addr_t         head_pc_q, head_pc_d;
    logic          inflight_q, inflight_d;
    logic          odd_q, odd_d;

    logic [0:CW]   count_w;
    need_t         need;
    logic          space_ok;
    logic          issue;
    logic          land;
    logic          pop;
    logic          valid;
    logic [1:0]    push_n;
    inst_t         push_w0, push_w1, head_inst;
    addr_t         redir_pc;
    logic          unused_bits;

    assign redir_pc = {bus.redirect_pc[0:61], 2'b00};

    // Reserve room for the read in flight as well as the new one.
    assign need = need_t'(count_w)
                + (need_t'(inflight_q) << 1)
                + need_t'(2);
    assign space_ok = need <= need_t'(DEPTH);

    assign issue = rst_n
                && !bus.fetch_stall
                && !bus.redirect_valid
                && space_ok;

    assign land   = inflight_q && !bus.redirect_valid;
    assign push_n = !land ? 2'd0 : (odd_q ? 2'd1 : 2'd2);

    assign push_w0 = odd_q ? bus.mem_rd_data[32:63]
                           : bus.mem_rd_data[0:31];
    assign push_w1 = bus.mem_rd_data[32:63];

    assign valid = (count_w != '0) && !bus.redirect_valid;
    assign pop   = valid && bus.inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = issue;
        odd_d      = fetch_pc_q[61];
        if (bus.redirect_valid) begin
            fetch_pc_d = redir_pc;
            head_pc_d  = redir_pc;
        end else begin
            if (issue)
                fetch_pc_d = next_dword(fetch_pc_q);
            if (pop)
                head_pc_d = head_pc_q + addr_t'(INST_BYTES);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            inflight_q <= 1'b0;
            odd_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            odd_q      <= odd_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_i   (bus.redirect_valid),
        .push_n_i  (push_n),
        .push_w0_i (push_w0),
        .push_w1_i (push_w1),
        .pop_i     (pop),
        .head_o    (head_inst),
        .count_o   (count_w)
    );

    assign bus.mem_rd_en   = issue;
    assign bus.mem_rd_addr = fetch_pc_q[0:60];
    assign bus.inst_valid  = valid;
    assign bus.inst        = head_inst;
    assign bus.inst_pc     = head_pc_q;
    assign bus.count       = count_w;

    assign unused_bits = ^{bus.redirect_pc[62:63], fetch_pc_q[62:63]};

`ifdef FETCH_QUEUE_PERF_EN
    logic [0:31] stall_cnt_q, stall_cnt_d;
    logic [0:31] redir_cnt_q, redir_cnt_d;
    logic        space_blk;

    assign space_blk = !bus.fetch_stall
                    && !bus.redirect_valid
                    && !space_ok;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        redir_cnt_d = redir_cnt_q;
        if (space_blk && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 32'd1;
        if (bus.redirect_valid && redir_cnt_q != '1)
            redir_cnt_d = redir_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            redir_cnt_q <= redir_cnt_d;
        end
    end

    assign bus.perf_stall_cycles = stall_cnt_q;
    assign bus.perf_redirects    = redir_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// Directed bench for fetch_queue_ctrl with a queue-of-PCs reference model.
module tb_fetch_queue_ctrl;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_queue_ctrl_if #(.DEPTH(DEPTH)) bus ();

    fetch_queue_ctrl #(
        .DEPTH    (DEPTH),
        .RESET_PC (64'h0)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word_at(logic [63:0] pc);
        return pc[31:0] ^ 32'hC0DE_0000;
    endfunction

    // Memory: answers one cycle after a request, garbage otherwise.
    logic        en_s = 1'b0;
    logic [60:0] addr_s;

    always @(negedge clk) begin
        en_s   = bus.mem_rd_en;
        addr_s = bus.mem_rd_addr;
    end

    always @(posedge clk) begin
        #1;
        if (en_s)
            bus.mem_rd_data = {word_at({addr_s, 3'b000}),
                               word_at({addr_s, 3'b100})};
        else
            bus.mem_rd_data = {$urandom, $urandom};
    end

    // Reference model: queue of the PCs that decode must see.
    logic [63:0] mq[$];
    logic [63:0] m_fpc = 64'h0;
    logic [63:0] m_ipc = 64'h0;
    bit          m_inf = 1'b0;
    bit          m_iss;
    bit          m_val;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_mem_rd_en", 64'(bus.mem_rd_en), 64'd0);
            chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
            chk("rst_count", 64'(bus.count), 64'd0);
            mq.delete();
            m_fpc = 64'h0;
            m_inf = 1'b0;
        end else begin
            m_iss = !bus.fetch_stall && !bus.redirect_valid
                 && (mq.size() + 2 * int'(m_inf) + 2 <= DEPTH);
            m_val = (mq.size() != 0) && !bus.redirect_valid;
            chk("mem_rd_en", 64'(bus.mem_rd_en), 64'(m_iss));
            if (m_iss)
                chk("mem_rd_addr", 64'(bus.mem_rd_addr), m_fpc >> 3);
            chk("inst_valid", 64'(bus.inst_valid), 64'(m_val));
            chk("count", 64'(bus.count), 64'(mq.size()));
            if (m_val) begin
                chk("inst_pc", bus.inst_pc, mq[0]);
                chk("inst", 64'(bus.inst), 64'(word_at(mq[0])));
            end
            if (bus.redirect_valid) begin
                mq.delete();
                m_fpc = bus.redirect_pc & ~64'h3;
                m_inf = 1'b0;
            end else begin
                if (m_val && bus.inst_ready)
                    void'(mq.pop_front());
                if (m_inf) begin
                    if (m_ipc[2]) begin
                        mq.push_back(m_ipc);
                    end else begin
                        mq.push_back(m_ipc);
                        mq.push_back(m_ipc + 64'd4);
                    end
                end
                m_inf = m_iss;
                if (m_iss) begin
                    m_ipc = m_fpc;
                    m_fpc = (m_fpc & ~64'h7) + 64'd8;
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    int  nrd;
    int  bubble;
    bit  seen;
    bit  found;

    initial begin
        rst_n              = 1'b0;
        bus.fetch_stall    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 64'h0;
        bus.inst_ready     = 1'b0;

        // Fill from reset with decode stalled.
        repeat (2) cyc();
        rst_n = 1'b1;
        nrd = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) nrd++;
        end
        chk("fill_reads", 64'(nrd), 64'd8);
        chk("fill_count", 64'(bus.count), 64'd16);
        chk("fill_inst_pc", bus.inst_pc, 64'h0);
        chk("fill_inst", 64'(bus.inst), 64'hC0DE_0000);
        chk("fill_no_issue", 64'(bus.mem_rd_en), 64'd0);

        // Drain two, then pop and land together at count 14.
        cyc();
        bus.fetch_stall = 1'b1;
        bus.inst_ready  = 1'b1;
        cyc();
        cyc();
        bus.fetch_stall = 1'b0;
        bus.inst_ready  = 1'b0;
        @(negedge clk);
        chk("c14_count", 64'(bus.count), 64'd14);
        chk("c14_issue", 64'(bus.mem_rd_en), 64'd1);
        cyc();
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("c14_infl_count", 64'(bus.count), 64'd14);
        chk("c14_infl_noissue", 64'(bus.mem_rd_en), 64'd0);
        cyc();
        @(negedge clk);
        chk("c15_count", 64'(bus.count), 64'd15);
        chk("c15_noissue", 64'(bus.mem_rd_en), 64'd0);
        cyc();
        @(negedge clk);
        chk("resume_count", 64'(bus.count), 64'd14);
        chk("resume_issue", 64'(bus.mem_rd_en), 64'd1);

        // Stream from reset with decode always ready.
        cyc();
        rst_n          = 1'b0;
        bus.inst_ready = 1'b1;
        cyc();
        cyc();
        rst_n  = 1'b1;
        bubble = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.inst_valid) seen = 1'b1;
            else if (seen) bubble++;
        end
        chk("stream_bubbles", 64'(bubble), 64'd0);
        chk("stream_pc", bus.inst_pc, 64'd148);

        // Unaligned redirect target.
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h106;
        bus.inst_ready     = 1'b0;
        cyc();
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        chk("redir_issue", 64'(bus.mem_rd_en), 64'd1);
        chk("redir_addr", 64'(bus.mem_rd_addr), 64'h20);
        chk("redir_flushed", 64'(bus.count), 64'd0);
        cyc();
        cyc();
        bus.inst_ready = 1'b1;
        @(negedge clk);
        chk("redir_count1", 64'(bus.count), 64'd1);
        chk("redir_pc0", bus.inst_pc, 64'h104);
        chk("redir_inst0", 64'(bus.inst), 64'(word_at(64'h104)));
        cyc();
        @(negedge clk);
        chk("redir_pc1", bus.inst_pc, 64'h108);

        // Redirect on top of a landing response.
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h200;
        cyc();
        bus.redirect_valid = 1'b0;
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h300;
        @(negedge clk);
        chk("kill_valid", 64'(bus.inst_valid), 64'd0);
        chk("kill_noissue", 64'(bus.mem_rd_en), 64'd0);
        cyc();
        bus.redirect_valid = 1'b0;
        bus.fetch_stall    = 1'b1;
        @(negedge clk);
        chk("kill_count", 64'(bus.count), 64'd0);
        chk("kill_valid2", 64'(bus.inst_valid), 64'd0);
        cyc();
        bus.fetch_stall = 1'b0;

        // Reset while a read is in flight.
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en) found = 1'b1;
        end
        chk("rst_wait_issue", 64'(found), 64'd1);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("arst_en", 64'(bus.mem_rd_en), 64'd0);
        chk("arst_valid", 64'(bus.inst_valid), 64'd0);
        chk("arst_count", 64'(bus.count), 64'd0);
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_issue", 64'(bus.mem_rd_en), 64'd1);
        chk("rel_addr", 64'(bus.mem_rd_addr), 64'h0);
        cyc();
        @(negedge clk);
        chk("rel_no_stale", 64'(bus.count), 64'd0);
        cyc();
        @(negedge clk);
        chk("rel_count", 64'(bus.count), 64'd2);
        chk("rel_pc", bus.inst_pc, 64'h0);
        chk("rel_inst", 64'(bus.inst), 64'hC0DE_0000);

        repeat (2) cyc();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
